instr_fetch: RTL and testbench

- Instruction fetch stage directly downstream of the CR16 program counter.
- Drives the pc load/advance controls, presents the pc address to the synchronous instruction memory, and registers the returned word.
- Hands instructions to decode over a valid/ready handshake; a two-entry output buffer absorbs decode stalls.
- Applies branch/jump redirects by loading the target into the pc and discarding stale instructions.

---
 rtl/cr16_pkg.sv | 28 ++
 rtl/fetch_buffer.sv | 97 +++++++++
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cr16_pkg.sv
// -----------------------------------------------------------------------------
// cr16_pkg
// Shared definitions for the CR16 fetch path.
//   C_ADDRESS_WIDTH / C_DATA_WIDTH : instruction address and word widths
//   C_RESET_ADDRESS                : default pc value applied during reset
//   fetch_entry_t                  : one buffered instruction {valid, data, address}
//   occupancy_t                    : fill level of the two-entry fetch buffer
// -----------------------------------------------------------------------------
package cr16_pkg;

    localparam int C_ADDRESS_WIDTH = 16;
    localparam int C_DATA_WIDTH    = 16;
    localparam logic [C_ADDRESS_WIDTH-1:0] C_RESET_ADDRESS = '0;

    typedef struct packed {
        logic                       valid;
        logic [C_DATA_WIDTH-1:0]    data;
        logic [C_ADDRESS_WIDTH-1:0] address;
    } fetch_entry_t;

    // Encoded so that the state value is also the number of held entries.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occupancy_t;

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Two-entry in-order buffer between the instruction memory and decode.
// The "out" entry is what decode sees; the "skid" entry catches a word that
// lands while out is stalled.
//   clk, srst    : clock, synchronous active-high reset (clears data as well)
//   push         : a fetched word is landing this cycle
//   push_entry   : the landing word (valid bit is ignored, forced high)
//   flush        : drop every held entry (redirect)
//   pop          : decode ready; consumes the head when it is valid
//   head_entry   : registered head of the buffer
//   full         : both entries held
//   count        : number of held entries (0..2)
// -----------------------------------------------------------------------------
module fetch_buffer
    import cr16_pkg::*;
(
    input  logic         clk,
    input  logic         srst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         flush,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic         full,
    output logic [1:0]   count
);

    occupancy_t   state_reg;
    fetch_entry_t out_reg;
    fetch_entry_t skid_reg;
    fetch_entry_t landing;

    always_comb begin
        landing       = push_entry;
        landing.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= OCC_EMPTY;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else if (flush) begin
            // Data fields are left alone so nothing but the valid bits toggle.
            state_reg      <= OCC_EMPTY;
            out_reg.valid  <= 1'b0;
            skid_reg.valid <= 1'b0;
        end else begin
            case (state_reg)
                OCC_EMPTY: begin
                    if (push) begin
                        out_reg   <= landing;
                        state_reg <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (pop) begin
                        if (push) begin
                            out_reg <= landing;
                        end else begin
                            out_reg.valid <= 1'b0;
                            state_reg     <= OCC_EMPTY;
                        end
                    end else if (push) begin
                        // Head is stalled: park the landing word behind it.
                        skid_reg  <= landing;
                        state_reg <= OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    // The fetch side never issues while full, so a push here
                    // can only coincide with a pop.
                    if (pop) begin
                        out_reg <= skid_reg;
                        if (push) begin
                            skid_reg <= landing;
                        end else begin
                            skid_reg.valid <= 1'b0;
                            state_reg      <= OCC_ONE;
                        end
                    end
                end
                default: begin
                    state_reg      <= OCC_EMPTY;
                    out_reg.valid  <= 1'b0;
                    skid_reg.valid <= 1'b0;
                end
            endcase
        end
    end

    assign head_entry = out_reg;
    assign full       = (state_reg == OCC_FULL);
    assign count      = state_reg;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage sitting directly after the CR16 program counter. Issues one
// read per cycle at the current pc, steps the pc, lands the synchronous
// memory word one cycle later into a two-entry buffer, and presents it to
// decode over valid/ready. Redirects load the pc and flush stale work.
//   I_CLK, I_RESET          : clock, synchronous active-high reset
//   I_ENABLE                : run enable (low stops issue, buffer still drains)
//   I_PC_ADDRESS            : current pc value
//   O_PC_ENABLE             : pc updates at the next edge when high
//   O_PC_ADDRESS_SELECT     : 1 = pc loads O_PC_ADDRESS, 0 = pc increments
//   O_PC_ADDRESS            : pc load value (reset address or redirect target)
//   O_MEM_READ/O_MEM_ADDRESS: read strobe/address to instruction memory
//   I_MEM_DATA              : read data, one cycle after O_MEM_READ
//   I_REDIRECT(_ADDRESS)    : taken branch/jump pulse and its target
//   O_INSTR_VALID/O_INSTR/O_INSTR_ADDRESS, I_INSTR_READY : decode handshake
// -----------------------------------------------------------------------------
module instr_fetch
    import cr16_pkg::*;
#(
    parameter int                         P_ADDRESS_WIDTH = C_ADDRESS_WIDTH,
    parameter int                         P_DATA_WIDTH    = C_DATA_WIDTH,
    parameter logic [P_ADDRESS_WIDTH-1:0] P_RESET_ADDRESS = C_RESET_ADDRESS
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic                       I_ENABLE,
    input  logic [P_ADDRESS_WIDTH-1:0] I_PC_ADDRESS,
    output logic                       O_PC_ENABLE,
    output logic                       O_PC_ADDRESS_SELECT,
    output logic [P_ADDRESS_WIDTH-1:0] O_PC_ADDRESS,
    output logic                       O_MEM_READ,
    output logic [P_ADDRESS_WIDTH-1:0] O_MEM_ADDRESS,
    input  logic [P_DATA_WIDTH-1:0]    I_MEM_DATA,
    input  logic                       I_REDIRECT,
    input  logic [P_ADDRESS_WIDTH-1:0] I_REDIRECT_ADDRESS,
    output logic                       O_INSTR_VALID,
    output logic [P_DATA_WIDTH-1:0]    O_INSTR,
    output logic [P_ADDRESS_WIDTH-1:0] O_INSTR_ADDRESS,
    input  logic                       I_INSTR_READY
);

    logic                       inflight_reg;
    logic [P_ADDRESS_WIDTH-1:0] inflight_address_reg;

    logic         issue;
    logic         push;
    logic         out_valid;
    logic         buffer_full;
    logic [1:0]   buffer_count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    assign out_valid = (buffer_count != 2'd0);

    // Only start a read if its word is guaranteed a slot when it lands:
    // a full buffer has no room, and a stalled head with a word already in
    // flight means that word will take the skid slot.
    assign issue = I_ENABLE && !I_RESET && !I_REDIRECT && !buffer_full
                   && !(out_valid && !I_INSTR_READY && inflight_reg);

    // A word landing on a redirect or reset edge is stale and is dropped.
    assign push = inflight_reg && !I_REDIRECT && !I_RESET;

    always_comb begin
        push_entry         = '0;
        push_entry.valid   = 1'b1;
        push_entry.data    = I_MEM_DATA;
        push_entry.address = inflight_address_reg;
    end

    // Reset outranks redirect, redirect outranks normal issue (and I_ENABLE).
    always_comb begin
        O_PC_ENABLE         = 1'b0;
        O_PC_ADDRESS_SELECT = 1'b0;
        O_PC_ADDRESS        = '0;
        if (I_RESET) begin
            O_PC_ENABLE         = 1'b1;
            O_PC_ADDRESS_SELECT = 1'b1;
            O_PC_ADDRESS        = P_RESET_ADDRESS;
        end else if (I_REDIRECT) begin
            O_PC_ENABLE         = 1'b1;
            O_PC_ADDRESS_SELECT = 1'b1;
            O_PC_ADDRESS        = I_REDIRECT_ADDRESS;
        end else if (issue) begin
            O_PC_ENABLE = 1'b1;
        end
    end

    assign O_MEM_READ    = issue;
    assign O_MEM_ADDRESS = I_PC_ADDRESS;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            inflight_reg         <= 1'b0;
            inflight_address_reg <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_address_reg <= I_PC_ADDRESS;
            end
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk        (I_CLK),
        .srst       (I_RESET),
        .push       (push),
        .push_entry (push_entry),
        .flush      (I_REDIRECT),
        .pop        (I_INSTR_READY),
        .head_entry (head_entry),
        .full       (buffer_full),
        .count      (buffer_count)
    );

    assign O_INSTR_VALID   = head_entry.valid;
    assign O_INSTR         = head_entry.data;
    assign O_INSTR_ADDRESS = head_entry.address;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Bench for instr_fetch with a behavioural pc and a 1-cycle synchronous
// instruction memory whose word at address a is a + 0x1000. Expected
// deliveries are queued by the stimulus; the monitor pops one per transfer.
// The DUT reset address is 0x0010.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] pc_reg;
    logic        pc_en;
    logic        pc_sel;
    logic [15:0] pc_load;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        ready;

    int          n_tests;
    int          n_fail;
    int          cyc;
    logic [31:0] sb[$];

    instr_fetch #(
        .P_ADDRESS_WIDTH (16),
        .P_DATA_WIDTH    (16),
        .P_RESET_ADDRESS (16'h0010)
    ) dut (
        .I_CLK               (clk),
        .I_RESET             (rst),
        .I_ENABLE            (enable),
        .I_PC_ADDRESS        (pc_reg),
        .O_PC_ENABLE         (pc_en),
        .O_PC_ADDRESS_SELECT (pc_sel),
        .O_PC_ADDRESS        (pc_load),
        .O_MEM_READ          (mem_read),
        .O_MEM_ADDRESS       (mem_addr),
        .I_MEM_DATA          (mem_data),
        .I_REDIRECT          (redirect),
        .I_REDIRECT_ADDRESS  (redirect_addr),
        .O_INSTR_VALID       (instr_valid),
        .O_INSTR             (instr),
        .O_INSTR_ADDRESS     (instr_addr),
        .I_INSTR_READY       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter: loads or increments (wrapping) when enabled.
    always_ff @(posedge clk) begin
        if (pc_en) pc_reg <= pc_sel ? pc_load : pc_reg + 16'd1;
    end

    // Instruction memory; junk on the bus when no read was issued.
    always_ff @(posedge clk) begin
        if (mem_read) mem_data <= mem_addr + 16'h1000;
        else          mem_data <= 16'hDEAD;
    end

    task automatic push_range(input logic [15:0] start, input int n);
        logic [15:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back({a, a + 16'h1000});
            a = a + 16'd1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: scoreboard compare on every transfer, plus directed checks.
    always @(negedge clk) begin
        if (!rst && instr_valid && ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", 64'({instr_addr, instr}), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("sb_transfer", 64'({instr_addr, instr}), 64'(sb.pop_front()));
            end
        end
        case (cyc)
            1:  check("first_latency_low", 64'(instr_valid), 64'd0);
            2:  check("first_valid", 64'({instr_valid, instr_addr}), 64'({1'b1, 16'h0010}));
            5:  check("stall_hold", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, 16'h0013, 16'h1013}));
            6, 7, 8: begin
                check("stall_hold", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, 16'h0013, 16'h1013}));
                check("full_no_fetch", 64'({pc_en, mem_read}), 64'd0);
            end
            15: check("redirect_ctl", 64'({pc_en, pc_sel, mem_read, pc_load}), 64'({3'b110, 16'h0030}));
            16: check("redirect_last", 64'({pc_en, pc_sel, mem_read, pc_load, instr_valid}),
                      64'({3'b110, 16'h0040, 1'b0}));
            17: check("redirect_issue", 64'({pc_reg, mem_read, mem_addr}), 64'({16'h0040, 1'b1, 16'h0040}));
            18: check("redirect_gap", 64'(instr_valid), 64'd0);
            19: check("redirect_latency", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, 16'h0040, 16'h1040}));
            22, 23: check("enable_low", 64'({pc_en, mem_read}), 64'd0);
            24: begin
                check("enable_low", 64'({pc_en, mem_read}), 64'd0);
                check("pc_hold", 64'(pc_reg), 64'h0045);
            end
            25: check("enable_resume", 64'({mem_read, mem_addr}), 64'({1'b1, 16'h0045}));
            30: check("stall_inflight", 64'({instr_valid, instr_addr, pc_en, mem_read}), 64'({1'b1, 16'h0048, 2'b00}));
            31: check("reset_ctl", 64'({pc_en, pc_sel, mem_read, pc_load}), 64'({3'b110, 16'h0010}));
            32: check("reset_clear", 64'({instr_valid, instr, instr_addr, pc_reg}),
                      64'({1'b0, 16'h0000, 16'h0000, 16'h0010}));
            34: check("reset_first", 64'({instr_valid, instr_addr}), 64'({1'b1, 16'h0010}));
            40: check("wrap_first", 64'({instr_valid, instr_addr}), 64'({1'b1, 16'hFFFE}));
            42: check("wrap_zero", 64'({instr_valid, instr_addr, instr}), 64'({1'b1, 16'h0000, 16'h1000}));
            47: check("drain_complete", 64'(sb.size()), 64'd0);
            default: ;
        endcase
    end

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        cyc           = -1;
        rst           = 1'b1;
        enable        = 1'b1;
        ready         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0BAD;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 47; c++) begin
            cyc    = c;
            rst    = (c == 31);
            ready  = !((c >= 5 && c <= 8) || c == 14 || c == 30 || c == 31 || c >= 45);
            enable = !(c >= 22 && c <= 24);
            redirect      = (c == 15) || (c == 16) || (c == 37);
            redirect_addr = (c == 15) ? 16'h0030 :
                            (c == 16) ? 16'h0040 :
                            (c == 37) ? 16'hFFFE : 16'h0BAD;
            if (c == 0)  push_range(16'h0010, 8);
            if (c == 17) push_range(16'h0040, 8);
            if (c == 32) push_range(16'h0010, 4);
            if (c == 37) push_range(16'hFFFE, 5);
            $display("[TB] cycle %0d rst=%0b en=%0b rdy=%0b redir=%0b tgt=%h", c, rst, enable, ready, redirect, redirect_addr);
            @(posedge clk);
            #1;
        end
        cyc      = 47;
        redirect = 1'b0;
        rst      = 1'b0;
        ready    = 1'b0;
        @(negedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
